// File: rtl/vga_timing_gen_if.sv
// Video port bundle for the raster timing generator: pixel-source request side,
// pixel data return, and DAC-facing sync/blank/colour outputs.
interface vga_timing_gen_if #(
    parameter int CW = 11
);
    logic          EN;
    logic [1:0]    MODE;
    logic [7:0]    PIX_R;
    logic [7:0]    PIX_G;
    logic [7:0]    PIX_B;
    logic [CW-1:0] X;
    logic [CW-1:0] Y;
    logic          REQ;
    logic [7:0]    VGA_R;
    logic [7:0]    VGA_G;
    logic [7:0]    VGA_B;
    logic          VGA_HS;
    logic          VGA_VS;
    logic          VGA_BLANK_N;
    logic          VGA_SYNC_N;
    logic          FRAME_START;
    logic          LINE_START;

    modport master (
        input  EN, MODE, PIX_R, PIX_G, PIX_B,
        output X, Y, REQ, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
               VGA_BLANK_N, VGA_SYNC_N, FRAME_START, LINE_START
    );

    modport slave (
        output EN, MODE, PIX_R, PIX_G, PIX_B,
        input  X, Y, REQ, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
               VGA_BLANK_N, VGA_SYNC_N, FRAME_START, LINE_START
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Programmable raster timing generator with delay-matched sync/blank and a
// frame-synchronous test-pattern mux in front of the DAC outputs.
module vga_timing_gen #(
    parameter int H_ACT   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_ACT   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int HS_POL  = 0,
    parameter int VS_POL  = 0,
    parameter int CW      = 11,
    parameter int PIX_LAT = 2
) (
    input  logic             VGA_CLK,
    input  logic             RESET,
    vga_timing_gen_if.master vif
);
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int BW    = H_ACT / 8;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOT - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOT - 1);
    localparam logic [CW-1:0] H_ACT_C    = CW'(H_ACT);
    localparam logic [CW-1:0] V_ACT_C    = CW'(V_ACT);
    localparam logic [CW-1:0] H_ACT_LAST = CW'(H_ACT - 1);
    localparam logic [CW-1:0] V_ACT_LAST = CW'(V_ACT - 1);
    localparam logic [CW-1:0] HS_BEG     = CW'(H_ACT + H_FP);
    localparam logic [CW-1:0] HS_END     = CW'(H_ACT + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG     = CW'(V_ACT + V_FP);
    localparam logic [CW-1:0] VS_END     = CW'(V_ACT + V_FP + V_SYNC);
    localparam logic          HS_ON      = 1'(HS_POL);
    localparam logic          VS_ON      = 1'(VS_POL);

    generate
        if (H_TOT >= (1 << CW) || V_TOT >= (1 << CW)) begin : g_chk_tot
            $error("vga_timing_gen: H_TOT or V_TOT does not fit in CW bits");
        end
        if (PIX_LAT < 0 || PIX_LAT > 7) begin : g_chk_lat
            $error("vga_timing_gen: PIX_LAT must be within 0..7");
        end
        if (H_ACT < 8 || V_ACT < 1 || CW < 5) begin : g_chk_geom
            $error("vga_timing_gen: H_ACT must be >= 8, V_ACT >= 1, CW >= 5");
        end
    endgenerate

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank_n;
        logic        fs;
        logic        ls;
        logic        pass;
        logic [23:0] pat;
    } stage_t;

    localparam stage_t STAGE_IDLE = '0;

    genvar gi;

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic [1:0]    mode_q, mode_d;
    logic          req;
    logic          origin;
    logic [1:0]    mode_s0;

    // Raster counters: h wraps every line, v steps on each h wrap.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (vif.EN) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    assign origin = (h_q == '0) && (v_q == '0);
    assign req    = (h_q < H_ACT_C) && (v_q < V_ACT_C);

    // The frame's first pixel already sees the MODE being latched, so a whole
    // frame is rendered with one mode.
    assign mode_s0 = origin ? vif.MODE : mode_q;
    assign mode_d  = (vif.EN && origin) ? vif.MODE : mode_q;

    always_ff @(posedge VGA_CLK or posedge RESET) begin
        if (RESET) begin
            h_q    <= '0;
            v_q    <= '0;
            mode_q <= 2'd0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            mode_q <= mode_d;
        end
    end

    // Bar index is the number of bar boundaries already passed; bar 7 keeps
    // any remainder of H_ACT/8.
    logic [7:1] bar_ge;
    logic [2:0] bar_idx;
    logic       grid_on;

    for (gi = 1; gi < 8; gi++) begin : g_bar
        assign bar_ge[gi] = (h_q >= CW'(gi * BW));
    end

    always_comb begin
        bar_idx = '0;
        for (int i = 1; i < 8; i++) begin
            bar_idx = bar_idx + {2'b00, bar_ge[i]};
        end
    end

    assign grid_on = (h_q[4:0] == 5'd0) || (v_q[4:0] == 5'd0) ||
                     (h_q == H_ACT_LAST) || (v_q == V_ACT_LAST);

    stage_t s0;

    always_comb begin
        s0         = STAGE_IDLE;
        s0.hs      = (h_q >= HS_BEG) && (h_q < HS_END);
        s0.vs      = (v_q >= VS_BEG) && (v_q < VS_END);
        s0.blank_n = req;
        s0.fs      = origin;
        s0.ls      = (h_q == '0) && (v_q < V_ACT_C);
        s0.pass    = (mode_s0 == 2'd0);
        case (mode_s0)
            2'd1:    s0.pat = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
            2'd2:    s0.pat = {24{grid_on}};
            default: s0.pat = '0;
        endcase
    end

    stage_t tap;

    for (gi = 1; gi <= PIX_LAT; gi++) begin : g_stage
        stage_t src;
        stage_t stage_q;
        if (gi == 1) begin : g_first
            assign src = s0;
        end else begin : g_next
            assign src = g_stage[gi-1].stage_q;
        end
        always_ff @(posedge VGA_CLK or posedge RESET) begin
            if (RESET) begin
                stage_q <= STAGE_IDLE;
            end else if (vif.EN) begin
                stage_q <= src;
            end
        end
    end

    if (PIX_LAT == 0) begin : g_tap_direct
        assign tap = s0;
    end else begin : g_tap_pipe
        assign tap = g_stage[PIX_LAT].stage_q;
    end

    logic        hs_q, vs_q, blank_q, fs_q, ls_q;
    logic [23:0] rgb_q, rgb_d;

    always_comb begin
        rgb_d = '0;
        if (tap.blank_n) begin
            rgb_d = tap.pass ? {vif.PIX_R, vif.PIX_G, vif.PIX_B} : tap.pat;
        end
    end

    always_ff @(posedge VGA_CLK or posedge RESET) begin
        if (RESET) begin
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
            rgb_q   <= '0;
        end else if (vif.EN) begin
            hs_q    <= tap.hs;
            vs_q    <= tap.vs;
            blank_q <= tap.blank_n;
            fs_q    <= tap.fs;
            ls_q    <= tap.ls;
            rgb_q   <= rgb_d;
        end
    end

    assign vif.X           = h_q;
    assign vif.Y           = v_q;
    assign vif.REQ         = req;
    assign vif.VGA_R       = rgb_q[23:16];
    assign vif.VGA_G       = rgb_q[15:8];
    assign vif.VGA_B       = rgb_q[7:0];
    assign vif.VGA_HS      = hs_q ? HS_ON : ~HS_ON;
    assign vif.VGA_VS      = vs_q ? VS_ON : ~VS_ON;
    assign vif.VGA_BLANK_N = blank_q;
    assign vif.VGA_SYNC_N  = 1'b0;
    // Pulses are gated so each lasts exactly one enabled cycle.
    assign vif.FRAME_START = fs_q & vif.EN;
    assign vif.LINE_START  = ls_q & vif.EN;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen on a small geometry, checked against a
// position-arithmetic reference model of the raster and pattern rules.
module tb_vga_timing_gen;
    localparam int HA = 20, HF = 2, HSW = 3, HB = 3;
    localparam int VA = 8, VF = 1, VSW = 2, VB = 2;
    localparam int HPOL = 1, VPOL = 0, CW = 11, LAT = 2;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FRAME = HT * VT;
    localparam int BW = HA / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.CW(CW)) vif();

    vga_timing_gen #(
        .H_ACT(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(HPOL), .VS_POL(VPOL), .CW(CW), .PIX_LAT(LAT)
    ) dut (
        .VGA_CLK(clk),
        .RESET(rst),
        .vif(vif)
    );

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          req;
        logic [23:0]   rgb;
        logic          hs;
        logic          vs;
        logic          blank_n;
        logic          sync_n;
        logic          fs;
        logic          ls;
    } obs_t;

    int vectors = 0;
    int miscompares = 0;

    int          m = 0;
    bit          cur_en = 1'b0;
    logic [1:0]  cur_mode = 2'd0;
    logic [23:0] cur_pix = '0;
    logic [23:0] cap_pix = '0;
    logic [1:0]  frame_mode [64];
    obs_t        exp_o, act_o;

    function automatic logic [23:0] bar_colour(input int idx);
        case (idx)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Outputs after m enabled edges show raster position m-(LAT+1).
    task automatic predict();
        int p, q, hq, vq, bi;
        bit act;
        p = m % FRAME;
        exp_o = '0;
        exp_o.x   = CW'(p % HT);
        exp_o.y   = CW'(p / HT);
        exp_o.req = ((p % HT) < HA) && ((p / HT) < VA);
        exp_o.hs  = ~1'(HPOL);
        exp_o.vs  = ~1'(VPOL);
        if (m >= LAT + 1) begin
            q  = m - LAT - 1;
            hq = (q % FRAME) % HT;
            vq = (q % FRAME) / HT;
            act = (hq < HA) && (vq < VA);
            exp_o.hs = (hq >= HA + HF && hq < HA + HF + HSW) ? 1'(HPOL) : ~1'(HPOL);
            exp_o.vs = (vq >= VA + VF && vq < VA + VF + VSW) ? 1'(VPOL) : ~1'(VPOL);
            exp_o.blank_n = act;
            exp_o.fs = (hq == 0 && vq == 0) && cur_en;
            exp_o.ls = (hq == 0 && vq < VA) && cur_en;
            if (act) begin
                bi = (hq / BW > 7) ? 7 : hq / BW;
                case (frame_mode[(q / FRAME) % 64])
                    2'd0: exp_o.rgb = cap_pix;
                    2'd1: exp_o.rgb = bar_colour(bi);
                    2'd2: exp_o.rgb = (hq % 32 == 0 || vq % 32 == 0 ||
                                       hq == HA - 1 || vq == VA - 1) ? 24'hFFFFFF : 24'h0;
                    default: exp_o.rgb = 24'h0;
                endcase
            end
        end
    endtask

    task automatic sample();
        act_o.x       = vif.X;
        act_o.y       = vif.Y;
        act_o.req     = vif.REQ;
        act_o.rgb     = {vif.VGA_R, vif.VGA_G, vif.VGA_B};
        act_o.hs      = vif.VGA_HS;
        act_o.vs      = vif.VGA_VS;
        act_o.blank_n = vif.VGA_BLANK_N;
        act_o.sync_n  = vif.VGA_SYNC_N;
        act_o.fs      = vif.FRAME_START;
        act_o.ls      = vif.LINE_START;
    endtask

    // One clock: advance the model on enabled edges, then drive new inputs
    // and capture expected/actual just after the falling edge.
    task automatic tick(input bit en, input logic [1:0] md);
        @(posedge clk);
        if (cur_en) begin
            if (m % FRAME == 0) frame_mode[(m / FRAME) % 64] = cur_mode;
            cap_pix = cur_pix;
            m++;
        end
        @(negedge clk);
        cur_en   = en;
        cur_mode = md;
        cur_pix  = 24'($urandom);
        vif.EN    = en;
        vif.MODE  = md;
        vif.PIX_R = cur_pix[23:16];
        vif.PIX_G = cur_pix[15:8];
        vif.PIX_B = cur_pix[7:0];
        #1;
        predict();
        sample();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        m = 0;
        predict();
        sample();
        vectors++;
        if (act_o !== exp_o) begin
            miscompares++;
            $display("FAIL reset_state act=%h exp=%h", act_o, exp_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        int hs_cnt = 0, vs_cnt = 0, bl_cnt = 0, fs_cnt = 0, ls_cnt = 0;
        int last_rise = -1;
        logic prev_hs = ~1'(HPOL);
        for (int k = 0; k < LAT + 4; k++) begin
            tick(1'b1, 2'd0);
            vectors++;
            if (act_o !== exp_o) begin
                miscompares++;
                $display("FAIL startup m=%0d act=%h exp=%h", m, act_o, exp_o);
            end
        end
        for (int t = 0; t < 2 * FRAME; t++) begin
            tick(1'b1, 2'd0);
            vectors++;
            if (act_o !== exp_o) begin
                miscompares++;
                $display("FAIL free_run m=%0d act=%h exp=%h", m, act_o, exp_o);
            end
            if (act_o.hs == 1'(HPOL)) hs_cnt++;
            if (act_o.vs == 1'(VPOL)) vs_cnt++;
            if (act_o.blank_n) bl_cnt++;
            if (act_o.fs) fs_cnt++;
            if (act_o.ls) ls_cnt++;
            if (act_o.hs == 1'(HPOL) && prev_hs != 1'(HPOL)) begin
                if (last_rise >= 0) begin
                    vectors++;
                    if (t - last_rise != HT) begin
                        miscompares++;
                        $display("FAIL hs_period act=%0d exp=%0d", t - last_rise, HT);
                    end
                end
                last_rise = t;
            end
            prev_hs = act_o.hs;
        end
        vectors += 5;
        if (hs_cnt != 2 * HSW * VT) begin
            miscompares++; $display("FAIL hs_count act=%0d exp=%0d", hs_cnt, 2 * HSW * VT);
        end
        if (vs_cnt != 2 * VSW * HT) begin
            miscompares++; $display("FAIL vs_count act=%0d exp=%0d", vs_cnt, 2 * VSW * HT);
        end
        if (bl_cnt != 2 * HA * VA) begin
            miscompares++; $display("FAIL blank_count act=%0d exp=%0d", bl_cnt, 2 * HA * VA);
        end
        if (fs_cnt != 2) begin
            miscompares++; $display("FAIL fs_count act=%0d exp=2", fs_cnt);
        end
        if (ls_cnt != 2 * VA) begin
            miscompares++; $display("FAIL ls_count act=%0d exp=%0d", ls_cnt, 2 * VA);
        end
    endtask

    task automatic test_patterns();
        for (int md = 1; md <= 3; md++) begin
            for (int k = 0; k < 2 * FRAME; k++) begin
                tick(1'b1, 2'(md));
                vectors++;
                if (act_o !== exp_o) begin
                    miscompares++;
                    $display("FAIL pattern mode=%0d m=%0d act=%h exp=%h", md, m, act_o, exp_o);
                end
            end
        end
    endtask

    task automatic test_en_toggle();
        logic [1:0] md = 2'd0;
        for (int k = 0; k < 4 * FRAME; k++) begin
            tick(k[0] == 1'b0, md);
            vectors++;
            if (act_o !== exp_o) begin
                miscompares++;
                $display("FAIL en_alt m=%0d act=%h exp=%h", m, act_o, exp_o);
            end
        end
        for (int k = 0; k < 3 * FRAME; k++) begin
            if ($urandom_range(0, 49) == 0) md = 2'($urandom);
            tick($urandom_range(0, 2) != 0, md);
            vectors++;
            if (act_o !== exp_o) begin
                miscompares++;
                $display("FAIL en_rand m=%0d act=%h exp=%h", m, act_o, exp_o);
            end
        end
    endtask

    task automatic test_mode_change();
        int guard = 0;
        while ((m % FRAME) != 4 * HT + 5 && guard < 2 * FRAME) begin
            tick(1'b1, 2'd0);
            guard++;
            vectors++;
            if (act_o !== exp_o) begin
                miscompares++;
                $display("FAIL mode_pre m=%0d act=%h exp=%h", m, act_o, exp_o);
            end
        end
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick(1'b1, 2'd1);
            vectors++;
            if (act_o !== exp_o) begin
                miscompares++;
                $display("FAIL mode_switch m=%0d act=%h exp=%h", m, act_o, exp_o);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int guard = 0;
        int fs_m = -1;
        while ((m % FRAME) != 5 * HT + 10 && guard < 2 * FRAME) begin
            tick(1'b1, 2'd2);
            guard++;
            vectors++;
            if (act_o !== exp_o) begin
                miscompares++;
                $display("FAIL rst_pre m=%0d act=%h exp=%h", m, act_o, exp_o);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        m = 0;
        predict();
        sample();
        vectors++;
        if (act_o !== exp_o) begin
            miscompares++;
            $display("FAIL rst_immediate act=%h exp=%h", act_o, exp_o);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < FRAME + LAT + 2; k++) begin
            tick(1'b1, 2'd2);
            vectors++;
            if (act_o !== exp_o) begin
                miscompares++;
                $display("FAIL rst_post m=%0d act=%h exp=%h", m, act_o, exp_o);
            end
            if (act_o.fs && fs_m < 0) fs_m = m;
        end
        vectors++;
        if (fs_m != LAT + 1) begin
            miscompares++;
            $display("FAIL rst_first_fs act=%0d exp=%0d", fs_m, LAT + 1);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) frame_mode[i] = 2'd0;
        vif.EN    = 1'b0;
        vif.MODE  = 2'd0;
        vif.PIX_R = 8'd0;
        vif.PIX_G = 8'd0;
        vif.PIX_B = 8'd0;
        test_reset();
        test_free_run();
        test_patterns();
        test_en_toggle();
        test_mode_change();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
